// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mips_ctrl_pkg                                                          |
// | Opcode/funct constants, select encodings and FSM state type shared by  |
// | the multicycle MIPS controller.                                        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    localparam logic [1:0] REGDST_RD = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_TRAP   = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    // Final state of every instruction; the edge leaving it retires the instruction.
    function automatic logic is_retire(input state_e s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB)  || (s == S_IWB) ||
               (s == S_BRANCH) || (s == S_JUMP) || (s == S_JAL) || (s == S_JR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu_op_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mips_alu_op_decode                                                     |
// | Combinational (opcode, funct) -> ALU operation and legal R-type flag.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mips_alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       rtype_legal_o
);

    always_comb begin
        alu_op_o      = ALU_ADD;
        rtype_legal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD: begin
                        alu_op_o      = ALU_ADD;
                        rtype_legal_o = 1'b1;
                    end
                    FN_SUB: begin
                        alu_op_o      = ALU_SUB;
                        rtype_legal_o = 1'b1;
                    end
                    FN_SLT: begin
                        alu_op_o      = ALU_SLT;
                        rtype_legal_o = 1'b1;
                    end
                    default: begin
                        alu_op_o      = ALU_ADD;
                        rtype_legal_o = 1'b0;
                    end
                endcase
            end
            OP_XORI:         alu_op_o = ALU_XOR;
            OP_BEQ, OP_BNE:  alu_op_o = ALU_SUB;
            default:         alu_op_o = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mips_multicycle_ctrl                                                   |
// | Multicycle MIPS control FSM: datapath selects, ALU op, write strobes,  |
// | sticky illegal-instruction flag and retired-instruction counter.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDstSel,
    output logic [1:0]       PcSel,
    output logic [1:0]       WbSel,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             Illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       dec_alu_op;
    logic             dec_rtype_legal;
    logic             branch_take;

    mips_alu_op_decode u_alu_op_decode (
        .opcode_i      (opcode),
        .funct_i       (funct),
        .alu_op_o      (dec_alu_op),
        .rtype_legal_o (dec_rtype_legal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_ADDR;
                    OP_RTYPE: begin
                        if (dec_rtype_legal)     state_d = S_RXEC;
                        else if (funct == FN_JR) state_d = S_JR;
                        else                     state_d = S_TRAP;
                    end
                    OP_ADDI, OP_XORI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_ADDR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_RXEC:   state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_MEMWR, S_RWB, S_IWB,
            S_BRANCH, S_JUMP, S_JAL, S_JR:
                      state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state they belong to.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.ir_write = 1'b1;
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_sel   = PC_PLUS4;
            end
            S_ADDR: begin
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEMWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = REGDST_RT;
                ctrl_d.wb_sel    = WB_MEM;
            end
            S_MEMWR: ctrl_d.mem_write = 1'b1;
            S_RXEC: begin
                ctrl_d.alu_src_b = 1'b0;
                ctrl_d.alu_op    = dec_alu_op;
            end
            S_RWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = REGDST_RD;
                ctrl_d.wb_sel    = WB_ALU;
                ctrl_d.alu_op    = dec_alu_op;
            end
            S_IEXEC: begin
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.alu_op    = dec_alu_op;
            end
            S_IWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = REGDST_RT;
                ctrl_d.wb_sel    = WB_ALU;
                ctrl_d.alu_op    = dec_alu_op;
            end
            S_BRANCH: begin
                ctrl_d.alu_op = ALU_SUB;
                ctrl_d.pc_sel = PC_BRANCH;
            end
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_sel   = PC_JUMP;
            end
            S_JAL: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_sel    = PC_JUMP;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = REGDST_RA;
                ctrl_d.wb_sel    = WB_PC4;
            end
            S_JR: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_sel   = PC_RS;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
            if (is_retire(state_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Branch PC load follows the live zero flag; opcode bit 0 distinguishes BNE from BEQ.
    assign branch_take = (state_q == S_BRANCH) &&
                         ((opcode == OP_BNE) ? ~zero : zero);

    assign PCWrite     = ctrl_q.pc_write | branch_take;
    assign IRWrite     = ctrl_q.ir_write;
    assign MemWrite    = ctrl_q.mem_write;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDstSel   = ctrl_q.reg_dst;
    assign PcSel       = ctrl_q.pc_sel;
    assign WbSel       = ctrl_q.wb_sel;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign Illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mips_multicycle_ctrl                                                |
// | Directed scoreboard bench for the multicycle MIPS controller.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_mips_multicycle_ctrl;

    localparam int T_IDLE = 0, T_FETCH = 1, T_DECODE = 2, T_ADDR = 3, T_MEMRD = 4,
                   T_MEMWB = 5, T_MEMWR = 6, T_RXEC = 7, T_RWB = 8, T_IEXEC = 9,
                   T_IWB = 10, T_BRANCH = 11, T_JUMP = 12, T_JAL = 13, T_JR = 14,
                   T_TRAP = 15;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] regdst;
        logic [1:0] pcsel;
        logic [1:0] wbsel;
        logic       srcb;
        logic [2:0] aluop;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic        Clk, Reset_n, zero;
    logic [5:0]  opcode, funct;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, ALUSrcB, Illegal;
    logic [1:0]  RegDstSel, PcSel, WbSel;
    logic [2:0]  ALUOp;
    logic [31:0] instr_count;

    logic        PCWrite4, IRWrite4, MemWrite4, RegWrite4, ALUSrcB4, Illegal4;
    logic [1:0]  RegDstSel4, PcSel4, WbSel4;
    logic [2:0]  ALUOp4;
    logic [3:0]  instr_count4;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDstSel(RegDstSel), .PcSel(PcSel), .WbSel(WbSel), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .Illegal(Illegal), .instr_count(instr_count)
    );

    mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWrite(PCWrite4), .IRWrite(IRWrite4), .MemWrite(MemWrite4), .RegWrite(RegWrite4),
        .RegDstSel(RegDstSel4), .PcSel(PcSel4), .WbSel(WbSel4), .ALUSrcB(ALUSrcB4),
        .ALUOp(ALUOp4), .Illegal(Illegal4), .instr_count(instr_count4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    exp_t        exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = '0;
    logic        exp_ill  = 1'b0;

    function automatic ctl_t act_ctl();
        return {PCWrite, IRWrite, MemWrite, RegWrite, RegDstSel, PcSel, WbSel,
                ALUSrcB, ALUOp, Illegal};
    endfunction

    function automatic ctl_t act_ctl4();
        return {PCWrite4, IRWrite4, MemWrite4, RegWrite4, RegDstSel4, PcSel4, WbSel4,
                ALUSrcB4, ALUOp4, Illegal4};
    endfunction

    task automatic compare(input exp_t e, input string nm);
        n_checks++;
        if ({act_ctl(), instr_count} !== {e.ctl, e.cnt}) begin
            n_errors++;
            $display("FAIL %s: ctl/count got %h/%0d expected %h/%0d",
                     nm, act_ctl(), instr_count, e.ctl, e.cnt);
        end
        n_checks++;
        if ({act_ctl4(), instr_count4} !== {e.ctl, e.cnt4}) begin
            n_errors++;
            $display("FAIL %s[CNT_W=4]: ctl/count got %h/%0d expected %h/%0d",
                     nm, act_ctl4(), instr_count4, e.ctl, e.cnt4);
        end
    endtask

    // Expected outputs for each state, written out from the control table.
    function automatic exp_t mk(input int st, input logic [2:0] aop, input logic take);
        exp_t e;
        e          = '0;
        e.ctl.ill  = exp_ill;
        e.cnt      = exp_cnt;
        e.cnt4     = exp_cnt[3:0];
        case (st)
            T_FETCH:  begin e.ctl.irw = 1; e.ctl.pcw = 1; end
            T_ADDR:   begin e.ctl.srcb = 1; end
            T_MEMWB:  begin e.ctl.regw = 1; e.ctl.regdst = 2'b01; e.ctl.wbsel = 2'b01; end
            T_MEMWR:  begin e.ctl.memw = 1; end
            T_RXEC:   begin e.ctl.aluop = aop; end
            T_RWB:    begin e.ctl.regw = 1; e.ctl.aluop = aop; end
            T_IEXEC:  begin e.ctl.srcb = 1; e.ctl.aluop = aop; end
            T_IWB:    begin e.ctl.regw = 1; e.ctl.regdst = 2'b01; e.ctl.aluop = aop; end
            T_BRANCH: begin e.ctl.aluop = 3'b001; e.ctl.pcsel = 2'b01; e.ctl.pcw = take; end
            T_JUMP:   begin e.ctl.pcw = 1; e.ctl.pcsel = 2'b10; end
            T_JAL:    begin e.ctl.pcw = 1; e.ctl.pcsel = 2'b10; e.ctl.regw = 1;
                            e.ctl.regdst = 2'b11; e.ctl.wbsel = 2'b10; end
            T_JR:     begin e.ctl.pcw = 1; e.ctl.pcsel = 2'b11; end
            default:  ;
        endcase
        return e;
    endfunction

    task automatic step(input int st, input logic [2:0] aop, input logic take, input string nm);
        @(posedge Clk);
        #1;
        exp_q.push_back(mk(st, aop, take));
        name_q.push_back(nm);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input string nm);
        step(T_FETCH, 3'b000, 1'b0, {nm, ".fetch"});
        opcode = op;
        funct  = fn;
        zero   = z;
        step(T_DECODE, 3'b000, 1'b0, {nm, ".decode"});
        case (op)
            6'h23: begin
                step(T_ADDR,  3'b000, 1'b0, {nm, ".addr"});
                step(T_MEMRD, 3'b000, 1'b0, {nm, ".memrd"});
                step(T_MEMWB, 3'b000, 1'b0, {nm, ".memwb"});
            end
            6'h2B: begin
                step(T_ADDR,  3'b000, 1'b0, {nm, ".addr"});
                step(T_MEMWR, 3'b000, 1'b0, {nm, ".memwr"});
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    step(T_JR, 3'b000, 1'b0, {nm, ".jr"});
                end else begin
                    logic [2:0] a;
                    a = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
                    step(T_RXEC, a, 1'b0, {nm, ".rxec"});
                    step(T_RWB,  a, 1'b0, {nm, ".rwb"});
                end
            end
            6'h08: begin
                step(T_IEXEC, 3'b000, 1'b0, {nm, ".iexec"});
                step(T_IWB,   3'b000, 1'b0, {nm, ".iwb"});
            end
            6'h0E: begin
                step(T_IEXEC, 3'b010, 1'b0, {nm, ".iexec"});
                step(T_IWB,   3'b010, 1'b0, {nm, ".iwb"});
            end
            6'h04: step(T_BRANCH, 3'b001, z,  {nm, ".branch"});
            6'h05: step(T_BRANCH, 3'b001, ~z, {nm, ".branch"});
            6'h02: step(T_JUMP, 3'b000, 1'b0, {nm, ".jump"});
            6'h03: step(T_JAL,  3'b000, 1'b0, {nm, ".jal"});
            default: ;
        endcase
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic run_trap(input logic [5:0] op, input logic [5:0] fn, input string nm);
        step(T_FETCH, 3'b000, 1'b0, {nm, ".fetch"});
        opcode = op;
        funct  = fn;
        step(T_DECODE, 3'b000, 1'b0, {nm, ".decode"});
        exp_ill = 1'b1;
        for (int i = 0; i < 22; i++) begin
            opcode = 6'(i);
            step(T_TRAP, 3'b000, 1'b0, {nm, ".trap"});
        end
    endtask

    // Asserts reset between clock edges and checks the outputs clear without a clock.
    task automatic do_reset(input string nm);
        Reset_n = 1'b0;
        #1;
        exp_cnt = '0;
        exp_ill = 1'b0;
        compare(mk(T_IDLE, 3'b000, 1'b0), {nm, ".async"});
        step(T_IDLE, 3'b000, 1'b0, {nm, ".hold"});
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        exp_q.push_back(mk(T_IDLE, 3'b000, 1'b0));
        name_q.push_back({nm, ".idle"});
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            compare(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        Reset_n = 1'b1;
        opcode  = '0;
        funct   = '0;
        zero    = 1'b0;
        #2;
        do_reset("por");

        run_instr(6'h00, 6'h20, 1'b0, "add");
        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h2B, 6'h00, 1'b0, "sw");
        run_instr(6'h00, 6'h22, 1'b0, "sub");
        run_instr(6'h00, 6'h2A, 1'b0, "slt");
        run_instr(6'h08, 6'h3F, 1'b0, "addi");
        run_instr(6'h0E, 6'h00, 1'b0, "xori");
        run_instr(6'h04, 6'h00, 1'b1, "beq_z1");
        run_instr(6'h04, 6'h00, 1'b0, "beq_z0");
        run_instr(6'h05, 6'h00, 1'b0, "bne_z0");
        run_instr(6'h05, 6'h00, 1'b1, "bne_z1");
        run_instr(6'h02, 6'h00, 1'b0, "j");
        run_instr(6'h03, 6'h00, 1'b0, "jal");
        run_instr(6'h00, 6'h08, 1'b0, "jr");

        run_trap(6'h3F, 6'h00, "trap_op3f");
        @(negedge Clk);
        #2;
        do_reset("trap_clr1");
        run_trap(6'h00, 6'h01, "trap_fn01");
        @(negedge Clk);
        #2;
        do_reset("trap_clr2");

        run_instr(6'h00, 6'h20, 1'b0, "add2");
        step(T_FETCH, 3'b000, 1'b0, "swmid.fetch");
        opcode = 6'h2B;
        funct  = 6'h00;
        step(T_DECODE, 3'b000, 1'b0, "swmid.decode");
        step(T_ADDR,   3'b000, 1'b0, "swmid.addr");
        step(T_MEMWR,  3'b000, 1'b0, "swmid.memwr");
        @(negedge Clk);
        #2;
        do_reset("swmid_rst");

        for (int i = 0; i < 16; i++) begin
            run_instr(6'h08, 6'h00, 1'b0, "addi_wrap");
        end
        step(T_FETCH, 3'b000, 1'b0, "wrap.fetch");
        @(negedge Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
